// File: rtl/div_clk_timekeeper_if.sv
// div_clk_timekeeper_if: software time-load handshake (valid/ready plus range-error pulse)
interface div_clk_timekeeper_if;
  logic       SET_VALID;
  logic       SET_READY;
  logic       SET_ERR;
  logic [4:0] SET_HOUR;
  logic [5:0] SET_MIN;
  logic [5:0] SET_SEC;
  modport master (output SET_VALID, SET_HOUR, SET_MIN, SET_SEC, input SET_READY, SET_ERR);
  modport slave (input SET_VALID, SET_HOUR, SET_MIN, SET_SEC, output SET_READY, SET_ERR);
endinterface

// File: rtl/div_clk_timekeeper.sv
// div_clk_timekeeper: DIV_CLK edge ticks prescaled into a 24h hh:mm:ss clock; alarm under TIMEKEEPER_ALARM_EN
module div_clk_timekeeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRE_W = 16
) (
  input  logic       CLK_IN,
  input  logic       nRST,
  input  logic       DIV_CLK,
  input  logic       RUN,
  div_clk_timekeeper_if.slave set_if,
  output logic       TICK,
  output logic       SEC_PULSE,
  output logic       DAY_PULSE,
  output logic [4:0] HOUR,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic [1:0] STATE
`ifdef TIMEKEEPER_ALARM_EN
  ,
  input  logic [4:0] ALARM_HOUR,
  input  logic [5:0] ALARM_MIN,
  input  logic       ALARM_ARM,
  output logic       ALARM
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, LOAD = 2'd2} state_t;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
  state_t           state_q;
  logic [2:0]       sync_q;
  logic             tick_q, sec_pulse_q, day_pulse_q, set_err_q, set_ready_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d, sec_q, sec_d;
  logic             in_range, load_ok, load_bad, adv, day_wrap;
  always_comb begin
    in_range = set_if.SET_HOUR <= 5'd23 && set_if.SET_MIN <= 6'd59 && set_if.SET_SEC <= 6'd59;
    load_ok  = set_if.SET_VALID && set_ready_q && in_range;
    load_bad = set_if.SET_VALID && set_ready_q && !in_range;
    adv      = state_q == COUNT && tick_q && pre_q == PRE_MAX;
    pre_d    = (state_q == COUNT && tick_q) ? (adv ? '0 : pre_q + 1'b1) : pre_q;
    sec_d    = sec_q == 6'd59 ? '0 : sec_q + 6'd1;
    min_d    = sec_q != 6'd59 ? min_q : (min_q == 6'd59 ? '0 : min_q + 6'd1);
    hour_d   = (sec_q != 6'd59 || min_q != 6'd59) ? hour_q : (hour_q == 5'd23 ? '0 : hour_q + 5'd1);
    day_wrap = hour_q == 5'd23 && min_q == 6'd59 && sec_q == 6'd59;
  end
  // an accepted load overrides a same-edge time advance and drops its pulses
  always_ff @(posedge CLK_IN) begin
    if (!nRST) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      tick_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      set_ready_q <= 1'b1;
      pre_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
    end else begin
      sync_q      <= {sync_q[1:0], DIV_CLK};
      tick_q      <= sync_q[1] & ~sync_q[2];
      set_err_q   <= load_bad;
      sec_pulse_q <= adv & ~load_ok;
      day_pulse_q <= adv & day_wrap & ~load_ok;
      if (load_ok) begin
        state_q     <= LOAD;
        set_ready_q <= 1'b0;
        pre_q       <= '0;
        hour_q      <= set_if.SET_HOUR;
        min_q       <= set_if.SET_MIN;
        sec_q       <= set_if.SET_SEC;
      end else begin
        state_q     <= RUN ? COUNT : IDLE;
        set_ready_q <= 1'b1;
        pre_q       <= pre_d;
        if (adv) begin
          hour_q <= hour_d;
          min_q  <= min_d;
          sec_q  <= sec_d;
        end
      end
    end
  end
`ifdef TIMEKEEPER_ALARM_EN
  logic alarm_q;
  always_ff @(posedge CLK_IN) begin
    if (!nRST) alarm_q <= 1'b0;
    else alarm_q <= ALARM_ARM && adv && !load_ok && hour_d == ALARM_HOUR && min_d == ALARM_MIN && sec_d == 6'd0;
  end
  assign ALARM = alarm_q;
`endif
  assign TICK             = tick_q;
  assign SEC_PULSE        = sec_pulse_q;
  assign DAY_PULSE        = day_pulse_q;
  assign HOUR             = hour_q;
  assign MIN              = min_q;
  assign SEC              = sec_q;
  assign STATE            = state_q;
  assign set_if.SET_READY = set_ready_q;
  assign set_if.SET_ERR   = set_err_q;
endmodule

// File: tb/tb_div_clk_timekeeper.sv
// tb_div_clk_timekeeper: directed stimulus with an event scoreboard for div_clk_timekeeper (TICKS_PER_SEC=4)
module tb_div_clk_timekeeper;
  typedef struct packed {
    logic       tick, sp, dp, err;
    logic [4:0] h;
    logic [5:0] m, s;
    logic [1:0] st;
  } ev_t;
  logic CLK_IN = 1'b0, nRST = 1'b0, DIV_CLK = 1'b0, RUN = 1'b0;
  logic TICK, SEC_PULSE, DAY_PULSE;
  logic [4:0] HOUR;
  logic [5:0] MIN, SEC;
  logic [1:0] STATE;
  ev_t exp_q[$];
  ev_t mon_a, mon_e;
  int n_cmp = 0, n_err = 0;
  div_clk_timekeeper_if sif();
`ifdef TIMEKEEPER_ALARM_EN
  logic ALARM;
`endif
  div_clk_timekeeper #(.TICKS_PER_SEC(4), .PRE_W(3)) dut (
    .CLK_IN(CLK_IN), .nRST(nRST), .DIV_CLK(DIV_CLK), .RUN(RUN), .set_if(sif),
    .TICK(TICK), .SEC_PULSE(SEC_PULSE), .DAY_PULSE(DAY_PULSE),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .STATE(STATE)
`ifdef TIMEKEEPER_ALARM_EN
    , .ALARM_HOUR(5'd0), .ALARM_MIN(6'd0), .ALARM_ARM(1'b0), .ALARM(ALARM)
`endif
  );
  always #5 CLK_IN = ~CLK_IN;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic push(input logic t, sp, dp, er, input logic [4:0] h, input logic [5:0] m, s, input logic [1:0] st);
    ev_t e;
    e.tick = t; e.sp = sp; e.dp = dp; e.err = er; e.h = h; e.m = m; e.s = s; e.st = st;
    exp_q.push_back(e);
  endtask
  // one DIV_CLK period: 4 cycles high, 4 low; optional load handshake presented at high-phase negedge ld_at
  task automatic div_pulse(input int ld_at, input logic [4:0] h, input logic [5:0] m, s);
    int lat;
    lat = 0;
    DIV_CLK = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK_IN);
      if (TICK && lat == 0) lat = i;
      if (ld_at != 0 && i == ld_at + 1) begin
        sif.SET_VALID = 1'b0;
        chk("load_state", STATE, 2);
        chk("load_ready", sif.SET_READY, 0);
        chk("load_no_sec_pulse", SEC_PULSE, 0);
        chk("load_time", {HOUR, MIN, SEC}, {h, m, s});
      end
      if (ld_at != 0 && i == ld_at) begin
        sif.SET_HOUR = h; sif.SET_MIN = m; sif.SET_SEC = s; sif.SET_VALID = 1'b1;
      end
    end
    chk("tick_latency", lat, 3);
    DIV_CLK = 1'b0;
    repeat (4) @(negedge CLK_IN);
  endtask
  task automatic pulse(input logic [1:0] st, input logic [4:0] h, input logic [5:0] m, s,
                       input logic adv, input logic [4:0] nh, input logic [5:0] nm, ns, input logic dp);
    push(1'b1, 1'b0, 1'b0, 1'b0, h, m, s, st);
    if (adv) push(1'b0, 1'b1, dp, 1'b0, nh, nm, ns, 2'd1);
    div_pulse(0, 5'd0, 6'd0, 6'd0);
  endtask
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, s);
    sif.SET_HOUR = h; sif.SET_MIN = m; sif.SET_SEC = s; sif.SET_VALID = 1'b1;
    @(negedge CLK_IN);
    sif.SET_VALID = 1'b0;
    chk("ld_state", STATE, 2);
    chk("ld_ready", sif.SET_READY, 0);
    chk("ld_time", {HOUR, MIN, SEC}, {h, m, s});
    @(negedge CLK_IN);
    chk("ld_exit_state", STATE, RUN ? 1 : 0);
    chk("ld_exit_ready", sif.SET_READY, 1);
  endtask
  always @(negedge CLK_IN) begin
    if (TICK || SEC_PULSE || DAY_PULSE || sif.SET_ERR) begin
      mon_a = {TICK, SEC_PULSE, DAY_PULSE, sif.SET_ERR, HOUR, MIN, SEC, STATE};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event got=%h expected=none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_err++;
          $display("FAIL event got=%h expected=%h", mon_a, mon_e);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end
  initial begin
    sif.SET_VALID = 1'b0; sif.SET_HOUR = '0; sif.SET_MIN = '0; sif.SET_SEC = '0;
    repeat (3) @(negedge CLK_IN);
    chk("rst_time", {HOUR, MIN, SEC}, 0);
    chk("rst_state", STATE, 0);
    chk("rst_pulses", {TICK, SEC_PULSE, DAY_PULSE, sif.SET_ERR}, 0);
    nRST = 1'b1;
    @(negedge CLK_IN);
    chk("rst_ready", sif.SET_READY, 1);
    for (int k = 0; k < 3; k++) pulse(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0);
    chk("idle_time", {HOUR, MIN, SEC}, 0);
    chk("idle_state", STATE, 0);
    RUN = 1'b1;
    @(negedge CLK_IN);
    chk("run_state", STATE, 1);
    for (int k = 0; k < 8; k++)
      pulse(2'd1, 5'd0, 6'd0, 6'(k / 4), k % 4 == 3, 5'd0, 6'd0, 6'(k / 4 + 1), 1'b0);
    do_load(5'd23, 6'd59, 6'd58);
    for (int k = 0; k < 4; k++) pulse(2'd1, 5'd23, 6'd59, 6'd58, k == 3, 5'd23, 6'd59, 6'd59, 1'b0);
    for (int k = 0; k < 4; k++) pulse(2'd1, 5'd23, 6'd59, 6'd59, k == 3, 5'd0, 6'd0, 6'd0, 1'b1);
    sif.SET_HOUR = 5'd5; sif.SET_MIN = 6'd60; sif.SET_SEC = 6'd0;
    push(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 6'd0, 6'd0, 2'd1);
    sif.SET_VALID = 1'b1;
    @(negedge CLK_IN);
    sif.SET_VALID = 1'b0;
    chk("bad_state", STATE, 1);
    chk("bad_time", {HOUR, MIN, SEC}, 0);
    chk("bad_ready", sif.SET_READY, 1);
    @(negedge CLK_IN);
    chk("bad_err_width", sif.SET_ERR, 0);
    for (int k = 0; k < 3; k++) pulse(2'd1, 5'd0, 6'd0, 6'd0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 2'd1);
    div_pulse(3, 5'd12, 6'd34, 6'd56);
    chk("wrap_load_state", STATE, 1);
    for (int k = 0; k < 4; k++) pulse(2'd1, 5'd12, 6'd34, 6'd56, k == 3, 5'd12, 6'd34, 6'd57, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 6'd2, 6'd3, 2'd2);
    div_pulse(2, 5'd1, 6'd2, 6'd3);
    for (int k = 0; k < 4; k++) pulse(2'd1, 5'd1, 6'd2, 6'd3, k == 3, 5'd1, 6'd2, 6'd4, 1'b0);
    DIV_CLK = 1'b1;
    sif.SET_HOUR = 5'd5; sif.SET_MIN = 6'd6; sif.SET_SEC = 6'd7; sif.SET_VALID = 1'b1;
    @(negedge CLK_IN);
    chk("pre_rst_state", STATE, 2);
    nRST = 1'b0; sif.SET_VALID = 1'b0; RUN = 1'b0;
    @(negedge CLK_IN);
    chk("mid_rst_time", {HOUR, MIN, SEC}, 0);
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_pulses", {TICK, SEC_PULSE, DAY_PULSE, sif.SET_ERR}, 0);
    DIV_CLK = 1'b0;
    @(negedge CLK_IN);
    nRST = 1'b1;
    repeat (8) @(negedge CLK_IN);
    chk("post_rst_state", STATE, 0);
    chk("post_rst_time", {HOUR, MIN, SEC}, 0);
    pulse(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0);
    repeat (4) @(negedge CLK_IN);
    chk("events_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_clk_timekeeper.md
Name: div_clk_timekeeper

Overview:
- Sits directly downstream of the odd-ratio clock divider in Time_Manager.
- Consumes the divided clock (DIV_CLK) as a data signal in the CLK_IN domain. Synchronises it and converts each rising edge into a one-cycle TICK enable.
- Prescales ticks into seconds and maintains a 24-hour hh:mm:ss time-of-day.
- Software loads the time through a valid/ready handshake.

Parameters:
- TICKS_PER_SEC, 1000: DIV_CLK rising edges per second; legal range 1..65535.
- PRE_W, 16: prescaler counter width; must satisfy 2^PRE_W > TICKS_PER_SEC-1.

Ports:
- CLK_IN  in  1  system clock; all logic on the posedge.
- nRST  in  1  reset, synchronous, active-low.
- DIV_CLK  in  1  divided clock from the divider; treated as asynchronous.
- RUN  in  1  1 = timekeeping advances, 0 = frozen.
- SET_VALID  in  1  load request.
- SET_READY  out  1  load can be accepted.
- SET_HOUR  in  5  load value, 0..23.
- SET_MIN  in  6  load value, 0..59.
- SET_SEC  in  6  load value, 0..59.
- SET_ERR  out  1  one-cycle pulse: out-of-range load rejected.
- TICK  out  1  one-cycle pulse per DIV_CLK rising edge.
- SEC_PULSE  out  1  one-cycle pulse when seconds advance.
- DAY_PULSE  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
- HOUR  out  5  current hour.
- MIN  out  6  current minute.
- SEC  out  6  current second.
- STATE  out  2  FSM state: 0 IDLE, 1 COUNT, 2 LOAD.

Behaviour:
- Reset (nRST=0 at a posedge):
  - sync flops = 0, prescaler = 0, HOUR/MIN/SEC = 0.
  - TICK/SEC_PULSE/DAY_PULSE/SET_ERR = 0.
  - STATE = IDLE; SET_READY = 1 in the first cycle after reset release.
  - Reset mid-operation aborts any load and discards partial prescale.
- Edge detect:
  - DIV_CLK feeds 3 flops s0 -> s1 -> s2.
  - TICK register <= s1 & ~s2.
  - Latency: DIV_CLK sampled high at edge k gives TICK high for the cycle after edge k+2.
  - Exactly one TICK per DIV_CLK rising edge. DIV_CLK high and low phases must each be >= 2 CLK_IN periods; shorter phases are unsupported.
  - TICK is generated in every state, independent of RUN.
- Prescaler: counts only in COUNT and only when TICK=1.
  - At TICKS_PER_SEC-1, a TICK wraps it to 0 and advances the time.
  - TICKS_PER_SEC=1 advances the time on every TICK.
- Time advance (single cycle, registered):
  - SEC+1; 59 wraps to 0 and carries to MIN.
  - MIN 59 wraps to 0 and carries to HOUR.
  - HOUR 23 wraps to 0.
  - SEC_PULSE is high the cycle after the advance edge, aligned with the new SEC value. DAY_PULSE is high in that same cycle on a full wrap.
- FSM:
  - IDLE -> COUNT when RUN=1. COUNT -> IDLE when RUN=0; prescaler holds its value (no clear).
  - IDLE/COUNT -> LOAD on a handshake (SET_VALID & SET_READY) with all fields in range.
  - On an out-of-range handshake: state unchanged, time unchanged, SET_ERR pulses for 1 cycle.
  - LOAD lasts exactly 1 cycle. Time registers take the SET values on the transfer edge and the prescaler clears. In LOAD, SET_READY=0 and ticks are ignored.
  - LOAD -> COUNT if RUN=1, else IDLE.
- SET_READY = 1 in IDLE/COUNT, 0 in LOAD. A SET_VALID held continuously is accepted again the cycle after LOAD.
- Simultaneous load handshake and time advance: load wins. Time equals the SET values, no SEC_PULSE, no DAY_PULSE.
- A TICK arriving in the LOAD cycle is dropped, not deferred.

Optional Feature:
- TIMEKEEPER_ALARM_EN:
  - Adds inputs ALARM_HOUR[4:0], ALARM_MIN[5:0], ALARM_ARM[0], and output ALARM[0].
  - ALARM pulses 1 cycle, aligned with SEC_PULSE, when ALARM_ARM=1 and the new time equals ALARM_HOUR:ALARM_MIN:00.
  - A load landing on the alarm time does not fire ALARM.
  - Without the macro, these ports and this logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset then DIV_CLK toggling every 4 CLK_IN cycles, RUN=0 -> TICK every 8 cycles, 3-cycle latency from DIV_CLK rise; STATE=0; time stays 00:00:00.
- TICKS_PER_SEC=4, RUN=1 -> SEC_PULSE after every 4th TICK; SEC counts 0,1,2...
- Load 23:59:58 (TICKS_PER_SEC=4) and run -> after 8 TICKS reaches 00:00:00. DAY_PULSE=1 in exactly the cycle SEC becomes 0.
- SET_VALID with SET_MIN=60 -> SET_ERR one cycle, time unchanged, STATE unchanged.
- Load 12:34:56 handshake on the same edge as a prescaler wrap -> time=12:34:56, no SEC_PULSE. SET_READY=0 for one cycle. The next SEC_PULSE comes a full TICKS_PER_SEC ticks later.
- nRST=0 asserted in the LOAD cycle and with DIV_CLK high -> all outputs 0 next cycle, STATE=IDLE. No spurious TICK unless DIV_CLK rises again after release.
